// File: rtl/swc_packet_mem_read_pump_pf_if.sv
// Bus bundle for the packet memory read pump.
// Groups the three sides of the pump:
//   page side   : pgaddr_i, pgreq_i, pgbusy_o, pgend_o, flush_i
//   memory side : sync_i, addr_o, rd_o, q_i
//   output side : drdy_o, dreq_i, d_o
// Signal suffixes are from the pump's point of view.
// modport master : the pump itself
// modport slave  : the environment (page logic, memory, output FIFO)
interface swc_packet_mem_read_pump_pf_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MULTIPLY       = 16,
  parameter int PAGE_ADDR_BITS = 10,
  parameter int LINE_BITS      = 3
);
  logic [PAGE_ADDR_BITS-1:0]           pgaddr_i;
  logic                                pgreq_i;
  logic                                pgbusy_o;
  logic                                pgend_o;
  logic                                sync_i;
  logic [PAGE_ADDR_BITS+LINE_BITS-1:0] addr_o;
  logic                                rd_o;
  logic [DATA_WIDTH*MULTIPLY-1:0]      q_i;
  logic                                flush_i;
  logic                                drdy_o;
  logic                                dreq_i;
  logic [DATA_WIDTH-1:0]               d_o;

  modport master (
    input  pgaddr_i, pgreq_i, sync_i, q_i, flush_i, dreq_i,
    output pgbusy_o, pgend_o, addr_o, rd_o, drdy_o, d_o
  );

  modport slave (
    output pgaddr_i, pgreq_i, sync_i, q_i, flush_i, dreq_i,
    input  pgbusy_o, pgend_o, addr_o, rd_o, drdy_o, d_o
  );
endinterface

// File: rtl/swc_packet_mem_read_pump_pf.sv
// Packet memory read pump with 2-line prefetch and next-page chaining.
// Fetches wide memory lines (MULTIPLY words) in the arbiter sync slot,
// buffers up to two lines and streams narrow words, LSB word first.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   bus      swc_packet_mem_read_pump_pf_if.master (page, memory, output)
//
// state | meaning
// IDLE  | no page active
// FETCH | issuing lines of cur_page in sync slots
// DRAIN | last line issued, waiting for buffer to empty or a new page
module swc_packet_mem_read_pump_pf #(
  parameter int DATA_WIDTH     = 32,
  parameter int MULTIPLY       = 16,
  parameter int PAGE_ADDR_BITS = 10,
  parameter int LINE_BITS      = 3
) (
  input  logic clk_i,
  input  logic rst_n_i,
  swc_packet_mem_read_pump_pf_if.master bus
);

  localparam int LINE_W = DATA_WIDTH * MULTIPLY;
  localparam int WIDX_W = (MULTIPLY > 1) ? $clog2(MULTIPLY) : 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [PAGE_ADDR_BITS-1:0] r_cur_page;
  logic [PAGE_ADDR_BITS-1:0] w_cur_page_nxt;
  logic [LINE_BITS:0]        r_line_cnt;
  logic [LINE_BITS:0]        w_line_cnt_nxt;
  logic [PAGE_ADDR_BITS-1:0] r_nxt_page;
  logic [PAGE_ADDR_BITS-1:0] w_nxt_page_nxt;
  logic                      r_nxt_valid;
  logic                      w_nxt_valid_nxt;

  logic [LINE_W-1:0]         r_buf [2];
  logic                      r_wr_ptr;
  logic                      r_rd_ptr;
  logic [1:0]                r_count;
  logic                      r_in_flight;
  logic [WIDX_W-1:0]         r_widx;

  logic                      w_issue;
  logic                      w_last;
  logic                      w_capture;
  logic                      w_xfer;
  logic                      w_retire;
  logic [1:0]                w_slots;
  logic [LINE_W-1:0]         w_rd_line;

  // Buffer slots committed = lines held plus the one on its way back.
  assign w_slots   = r_count + {1'b0, r_in_flight};
  assign w_issue   = (r_state == S_FETCH) && bus.sync_i && (w_slots < 2'd2) && !bus.flush_i;
  assign w_last    = &r_line_cnt[LINE_BITS-1:0];
  assign w_capture = r_in_flight && !bus.flush_i;
  assign w_xfer    = (r_count != 2'd0) && bus.dreq_i && !bus.flush_i;
  assign w_retire  = w_xfer && (r_widx == WIDX_W'(MULTIPLY - 1));
  assign w_rd_line = r_buf[r_rd_ptr];

  assign bus.rd_o     = w_issue;
  assign bus.addr_o   = w_issue ? {r_cur_page, r_line_cnt[LINE_BITS-1:0]} : '0;
  assign bus.pgend_o  = w_issue && w_last;
  assign bus.pgbusy_o = r_nxt_valid;
  assign bus.drdy_o   = (r_count != 2'd0);
  assign bus.d_o      = (r_count != 2'd0) ?
                        w_rd_line[int'(r_widx)*DATA_WIDTH +: DATA_WIDTH] : '0;

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_page_nxt  = r_cur_page;
    w_line_cnt_nxt  = r_line_cnt;
    w_nxt_page_nxt  = r_nxt_page;
    w_nxt_valid_nxt = r_nxt_valid;
    if (bus.flush_i) begin
      w_state_nxt     = S_IDLE;
      w_line_cnt_nxt  = '0;
      w_nxt_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.pgreq_i) begin
            w_cur_page_nxt = bus.pgaddr_i;
            w_line_cnt_nxt = '0;
            w_state_nxt    = S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_issue) w_line_cnt_nxt = r_line_cnt + 1'b1;
          if (w_issue && w_last) begin
            if (r_nxt_valid) begin
              w_cur_page_nxt  = r_nxt_page;
              w_line_cnt_nxt  = '0;
              w_nxt_valid_nxt = 1'b0;
            end else if (bus.pgreq_i) begin
              // Request lands on the final issue: chain it directly
              // instead of parking it and stalling in DRAIN.
              w_cur_page_nxt = bus.pgaddr_i;
              w_line_cnt_nxt = '0;
            end else begin
              w_state_nxt = S_DRAIN;
            end
          end else if (bus.pgreq_i && !r_nxt_valid) begin
            w_nxt_page_nxt  = bus.pgaddr_i;
            w_nxt_valid_nxt = 1'b1;
          end
        end
        S_DRAIN: begin
          if (bus.pgreq_i) begin
            w_cur_page_nxt = bus.pgaddr_i;
            w_line_cnt_nxt = '0;
            w_state_nxt    = S_FETCH;
          end else if ((r_count == 2'd0) && !r_in_flight) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_IDLE;
      r_cur_page  <= '0;
      r_line_cnt  <= '0;
      r_nxt_page  <= '0;
      r_nxt_valid <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_count     <= 2'd0;
      r_in_flight <= 1'b0;
      r_widx      <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_page  <= w_cur_page_nxt;
      r_line_cnt  <= w_line_cnt_nxt;
      r_nxt_page  <= w_nxt_page_nxt;
      r_nxt_valid <= w_nxt_valid_nxt;
      if (bus.flush_i) begin
        r_wr_ptr    <= 1'b0;
        r_rd_ptr    <= 1'b0;
        r_count     <= 2'd0;
        r_in_flight <= 1'b0;
        r_widx      <= '0;
      end else begin
        r_in_flight <= w_issue;
        if (w_capture) r_wr_ptr <= ~r_wr_ptr;
        if (w_xfer) begin
          if (w_retire) begin
            r_widx   <= '0;
            r_rd_ptr <= ~r_rd_ptr;
          end else begin
            r_widx <= r_widx + 1'b1;
          end
        end
        // Capture and retire together leave the occupancy unchanged.
        case ({w_capture, w_retire})
          2'b10:   r_count <= r_count + 2'd1;
          2'b01:   r_count <= r_count - 2'd1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Line storage needs no reset; r_count marks which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_capture) r_buf[r_wr_ptr] <= bus.q_i;
  end

endmodule

// File: tb/tb_swc_packet_mem_read_pump_pf.sv
module tb_swc_packet_mem_read_pump_pf;
  localparam int DW = 32;
  localparam int M  = 16;
  localparam int PB = 10;
  localparam int LB = 3;
  localparam int L  = 8;
  localparam int AW = PB + LB;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  swc_packet_mem_read_pump_pf_if bus ();
  swc_packet_mem_read_pump_pf dut (.clk_i(clk), .rst_n_i(rst_n), .bus(bus));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Memory content: word k of line n of page p = {p, n, k}
  function automatic logic [DW-1:0] mkword(input logic [PB-1:0] p, input logic [LB-1:0] n, input int k);
    return {6'd0, p, 5'd0, n, 8'(k)};
  endfunction

  function automatic logic [DW*M-1:0] mkline(input logic [AW-1:0] a);
    logic [DW*M-1:0] v;
    for (int k = 0; k < M; k++) v[k*DW +: DW] = mkword(a[AW-1:LB], a[LB-1:0], k);
    return v;
  endfunction

  // Reference model: queue of pending pages, queue of buffered lines,
  // one line in flight, position inside the head line.
  typedef struct { logic [PB-1:0] page; int nl; } pend_t;
  pend_t          m_pend[$];
  logic [AW-1:0]  m_lines[$];
  bit             m_inf;
  logic [AW-1:0]  m_inf_line;
  int             m_widx;

  task automatic model_reset();
    m_pend.delete();
    m_lines.delete();
    m_inf  = 1'b0;
    m_widx = 0;
  endtask

  bit            rd_smp;
  logic [AW-1:0] addr_smp;
  int n_words, n_rd, n_pgend, n_gap, target;
  bit started;

  typedef struct {
    bit pgreq; logic [PB-1:0] pa; bit sync; bit dreq; bit flush;
    bit e_rd; logic [AW-1:0] e_addr; bit e_busy; bit e_drdy; bit e_pgend; logic [DW-1:0] e_d;
  } vec_t;
  vec_t vecs[12];
  vec_t cur;
  bit   vec_on = 1'b0;

  task automatic model_step();
    bit issue, accept, xfer, e_drdy, e_pgend;
    logic [AW-1:0] a;
    logic [DW-1:0] e_d;
    pend_t t;
    e_drdy = m_lines.size() > 0;
    e_d    = e_drdy ? mkword(m_lines[0][AW-1:LB], m_lines[0][LB-1:0], m_widx) : '0;
    issue  = !bus.flush_i && (m_pend.size() > 0) && bus.sync_i && ((m_lines.size() + int'(m_inf)) < 2);
    a      = issue ? {m_pend[0].page, LB'(m_pend[0].nl)} : '0;
    e_pgend = issue && (m_pend[0].nl == L - 1);
    chk("rd",     64'(bus.rd_o),     64'(issue));
    chk("addr",   64'(bus.addr_o),   64'(a));
    chk("pgend",  64'(bus.pgend_o),  64'(e_pgend));
    chk("pgbusy", 64'(bus.pgbusy_o), 64'(m_pend.size() == 2));
    chk("drdy",   64'(bus.drdy_o),   64'(e_drdy));
    chk("d",      64'(bus.d_o),      64'(e_d));

    rd_smp   = bus.rd_o;
    addr_smp = bus.addr_o;
    if (bus.rd_o) n_rd++;
    if (bus.pgend_o) n_pgend++;
    if (started && !bus.drdy_o && n_words < target) n_gap++;
    if (bus.drdy_o && bus.dreq_i && !bus.flush_i) begin
      n_words++;
      started = 1'b1;
    end

    if (bus.flush_i) begin
      model_reset();
    end else begin
      accept = bus.pgreq_i && (m_pend.size() < 2);
      xfer   = e_drdy && bus.dreq_i;
      if (xfer) begin
        m_widx++;
        if (m_widx == M) begin
          m_widx = 0;
          void'(m_lines.pop_front());
        end
      end
      if (m_inf) m_lines.push_back(m_inf_line);
      m_inf = issue;
      if (issue) begin
        m_inf_line = a;
        t = m_pend[0];
        t.nl++;
        if (t.nl == L) void'(m_pend.pop_front());
        else m_pend[0] = t;
      end
      if (accept) m_pend.push_back('{bus.pgaddr_i, 0});
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (vec_on) begin
      chk("vec_rd",     64'(bus.rd_o),     64'(cur.e_rd));
      chk("vec_addr",   64'(bus.addr_o),   64'(cur.e_addr));
      chk("vec_pgbusy", 64'(bus.pgbusy_o), 64'(cur.e_busy));
      chk("vec_drdy",   64'(bus.drdy_o),   64'(cur.e_drdy));
      chk("vec_pgend",  64'(bus.pgend_o),  64'(cur.e_pgend));
      chk("vec_d",      64'(bus.d_o),      64'(cur.e_d));
    end
    model_step();
    @(posedge clk);
    #1;
    bus.q_i = rd_smp ? mkline(addr_smp) : '0;
  endtask

  task automatic stream(input logic [PB-1:0] p0, input int npages, input bit bp, input string name);
    int cyc;
    n_words = 0; n_rd = 0; n_pgend = 0; n_gap = 0; started = 1'b0;
    target = npages * M * L;
    cyc = 0;
    while (n_words < target && cyc < 3000) begin
      bus.pgreq_i  = (cyc == 0) || (npages == 2 && cyc == 3);
      bus.pgaddr_i = (cyc == 0) ? p0 : p0 + 10'd1;
      bus.sync_i   = (cyc % 16) == 1;
      bus.dreq_i   = bp ? ((cyc % 2) == 0) : 1'b1;
      bus.flush_i  = 1'b0;
      tick();
      cyc++;
    end
    bus.pgreq_i = 1'b0; bus.sync_i = 1'b0; bus.dreq_i = 1'b0;
    repeat (3) tick();
    chk({name, "_words"}, 64'(n_words), 64'(target));
    chk({name, "_rd"},    64'(n_rd),    64'(npages * L));
    chk({name, "_pgend"}, 64'(n_pgend), 64'(npages));
    if (!bp) chk({name, "_gap"}, 64'(n_gap), 64'(0));
  endtask

  initial begin
    vecs[0]  = '{1'b1, 10'h005, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b1, 10'h006, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0028, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[3]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b1, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h0029, 1'b1, 1'b1, 1'b0, 32'h00050000};
    vecs[5]  = '{1'b1, 10'h007, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0000, 1'b1, 1'b1, 1'b0, 32'h00050000};
    vecs[6]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 10'h3FF, 1'b1, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 1'b1, 13'h1FF8, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[9]  = '{1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 32'h03FF0000};
    vecs[11] = '{1'b0, 10'h000, 1'b0, 1'b1, 1'b0, 1'b0, 13'h0000, 1'b0, 1'b1, 1'b0, 32'h03FF0001};

    rst_n = 1'b0;
    bus.pgreq_i = 1'b0; bus.pgaddr_i = '0; bus.sync_i = 1'b0; bus.q_i = '0;
    bus.flush_i = 1'b0; bus.dreq_i = 1'b0;
    target = 0; n_words = 0; n_rd = 0; n_pgend = 0; n_gap = 0; started = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_drdy",   64'(bus.drdy_o),   64'(0));
    chk("reset_pgbusy", 64'(bus.pgbusy_o), 64'(0));
    rst_n = 1'b1;

    // Directed vectors: chaining request, flush right after a read,
    // restart of a new page at line 0 / word 0.
    vec_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      cur = vecs[i];
      bus.pgreq_i  = cur.pgreq;
      bus.pgaddr_i = cur.pa;
      bus.sync_i   = cur.sync;
      bus.dreq_i   = cur.dreq;
      bus.flush_i  = cur.flush;
      tick();
    end
    vec_on = 1'b0;

    // Reset for one cycle in the middle of page 0x3FF.
    bus.pgreq_i = 1'b0; bus.sync_i = 1'b1; bus.dreq_i = 1'b1; bus.flush_i = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_rd",     64'(bus.rd_o),     64'(0));
    chk("rst_addr",   64'(bus.addr_o),   64'(0));
    chk("rst_pgbusy", 64'(bus.pgbusy_o), 64'(0));
    chk("rst_pgend",  64'(bus.pgend_o),  64'(0));
    chk("rst_drdy",   64'(bus.drdy_o),   64'(0));
    chk("rst_d",      64'(bus.d_o),      64'(0));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.sync_i = 1'b0; bus.dreq_i = 1'b0; bus.q_i = '0;
    model_reset();

    stream(10'h012, 1, 1'b0, "single");
    stream(10'h005, 2, 1'b0, "chain");
    stream(10'h0A0, 1, 1'b1, "backpressure");

    // Randomized traffic against the model.
    target = 0;
    for (int c = 0; c < 3000; c++) begin
      bus.pgreq_i  = ($urandom % 8) == 0;
      bus.pgaddr_i = 10'($urandom);
      bus.sync_i   = ($urandom % 4) == 0;
      bus.dreq_i   = ($urandom % 4) != 0;
      bus.flush_i  = ($urandom % 97) == 0;
      tick();
    end
    bus.pgreq_i = 1'b0; bus.sync_i = 1'b0; bus.dreq_i = 1'b0; bus.flush_i = 1'b0;
    repeat (2) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
